core_pipe_exec_mdu_ctrl: RTL and testbench
==========================================

# core_pipe_exec_mdu_ctrl

Sequencer between the execute stage and the multiply/divide unit (MDU). It accepts one request at a time from the pipeline, registers the operands and operation, and holds them stable at the MDU until it signals ready. It then buffers the result until the pipeline accepts it, and pulses the MDU flush so the unit can accept its next operation. Division by zero and signed division overflow are resolved locally without engaging the MDU.

## Interface
- `XLEN`, 64: datapath width; `XL` = `XLEN-1`.
- `g_clk` in 1: clock.
- `g_resetn` in 1: reset, asynchronous and active-low.
- `pipe_flush` in 1: abandon any in-flight operation.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_op_word` in 1: 32-bit word operation.
- `req_op` in 8: one-hot op, bit 0..7 = mul, mulh, mulhu, mulhsu, div, divu, rem, remu.
- `req_rs1`, `req_rs2` in XLEN: source operands.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: pipeline consumes the result.
- `rsp_rd` out XLEN: result.
- `mdu_valid` out 1: MDU operation request.
- `mdu_op_word` out 1, `mdu_op` out 8, `mdu_rs1`/`mdu_rs2` out XLEN: registered operation and operands.
- `mdu_flush` out 1: clears MDU run/done state.
- `mdu_ready` in 1, `mdu_rd` in XLEN: MDU completion and result.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, RUN, CLR, RESP.
- **Accept** on `req_valid && req_ready`.
  - `req_ready = (state==IDLE) && !pipe_flush`.
  - On accept, `req_op_word`, `req_op`, `req_rs1` and `req_rs2` are registered into the `mdu_*` outputs.
- **Fast path** (IDLE→RESP). Taken on accept when the op is div/divu/rem/remu and either condition holds:
  - **Divisor zero:** `rs2 == 0`, using `rs2[31:0]` only when word.
    - div/divu result: all ones.
    - rem/remu result: `rs1`, or `sext(rs1[31:0])` when word.
  - **Signed overflow:** div/rem with `rs1` = most-negative value (`0x8000_0000` in the low 32 bits when word) and `rs2` = all ones (low 32 bits when word).
    - div result: `rs1`, or `sext(rs1[31:0])` when word.
    - rem result: 0.
  - The result is written into `rsp_rd` on the accept edge. The MDU is not started.
- **Normal path:** IDLE→RUN on accept.
  - RUN: `mdu_valid=1`, and all `mdu_*` operand/op outputs are held constant.
  - On `mdu_ready` in RUN: register `mdu_rd` into `rsp_rd`, then go to CLR.
- **CLR:**
  - Outputs: `mdu_flush=1`, `mdu_valid=0`, `rsp_valid=1`.
  - With `rsp_ready`: go to IDLE. Otherwise go to RESP.
- **RESP:**
  - Outputs: `rsp_valid=1`, `mdu_flush=0`.
  - With `rsp_ready`: go to IDLE.
- `rsp_rd` stays stable while `rsp_valid=1`.
- `mdu_flush = (state==CLR) || pipe_flush`.
- **`pipe_flush`** (any state):
  - Next state is IDLE.
  - `rsp_valid` and `mdu_valid` are forced low in the same cycle.
  - Any pending result is discarded, and no accept occurs.
  - Flush takes priority over `mdu_ready` and `rsp_ready` in the same cycle.
- **Illegal input:** `req_op` not one-hot on accept is a protocol violation. Assert it in simulation. RTL behaviour is undefined.

## Timing
- **Reset (async):**
  - State IDLE.
  - `rsp_valid=0`, `rsp_rd=0`, `mdu_valid=0`, `mdu_op=0`, `mdu_op_word=0`, `mdu_rs1=0`, `mdu_rs2=0`, `busy=0`.
  - `mdu_flush=0` unless `pipe_flush`.
  - `req_ready=1` when `pipe_flush=0`.
  - Reset mid-operation returns to these values immediately. The MDU's own reset clears it.
- **Normal latency:**
  - Accept at edge T; `mdu_valid` is high from T+1.
  - When `mdu_ready` is sampled at edge T+1+k, `rsp_valid` is high from that edge (CLR state).
  - Controller overhead: 1 cycle in, 1 cycle out.
- **Fast-path latency:** accept at edge T; `rsp_valid` high from T+1.
- **Back-to-back:** response accepted at edge E; the next request can be accepted at edge E+1. Throughput ≤ 1 op per (MDU latency + 2) cycles.
- **MDU flush timing:** `mdu_flush` is high for exactly one cycle per normal op, the cycle after `mdu_ready`, independent of `rsp_ready`.
- **Handshakes:**
  - `req_ready` does not depend on `rsp_ready`.
  - `rsp_valid` does not depend combinationally on `rsp_ready`.

## Test plan
- **MUL:** `mul` rs1=7, rs2=6, `rsp_ready=1` → `rsp_rd=42`; `mdu_flush` pulses one cycle; `req_ready` high again the cycle after the response.
- **Divide by zero:** `divu` rs1=100, rs2=0 → `rsp_valid` at T+1, `rsp_rd=0xFFFF_FFFF_FFFF_FFFF`, `mdu_valid` never high. `remw` rs1=0x1_8000_0005, rs2=0 → `rsp_rd=0xFFFF_FFFF_8000_0005`.
- **Signed overflow:** `div` rs1=0x8000_0000_0000_0000, rs2=-1 → `rsp_rd=0x8000_0000_0000_0000`. `remw` rs1=0x8000_0000, rs2=0xFFFF_FFFF → `rsp_rd=0`.
- **Backpressure:** `divw` rs1=-20, rs2=3 with `rsp_ready` held low 5 cycles → `rsp_rd=0xFFFF_FFFF_FFFF_FFFA` stable throughout, `req_ready=0`; on release, back to IDLE.
- **Flush mid-run:** `pipe_flush` asserted 10 cycles into a `mulh` → `mdu_flush=1` that cycle, IDLE next, no `rsp_valid`. A following `mulhu` rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → `rsp_rd=0xFFFF_FFFF_FFFF_FFFE`.
- **Async reset:** assert `g_resetn=0` between clock edges in RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/core_pipe_exec_mdu_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_pipe_exec_mdu_ctrl_if
//
// This interface bundles every signal between the execute-stage MDU
// sequencer and its two neighbours: the pipeline on one side and the
// multiply/divide unit on the other. Clock and reset are not part of it.
//
// Signals are listed from the sequencer's point of view.
//   pipe_flush              in   abandon any in-flight operation
//   req_valid / req_ready   in/out  request handshake from the pipeline
//   req_op_word             in   32-bit word operation
//   req_op[7:0]             in   one-hot op: mul,mulh,mulhu,mulhsu,div,divu,rem,remu
//   req_rs1 / req_rs2       in   source operands
//   rsp_valid / rsp_ready   out/in  response handshake to the pipeline
//   rsp_rd                  out  result
//   mdu_valid               out  operation request to the MDU
//   mdu_op_word / mdu_op    out  registered operation
//   mdu_rs1 / mdu_rs2       out  registered operands
//   mdu_flush               out  clears the MDU run/done state
//   mdu_ready / mdu_rd      in   MDU completion and result
//   busy                    out  sequencer not idle
//
// Modports:
//   slave  - the sequencer
//   master - the environment (pipeline + MDU)
// ---------------------------------------------------------------------------
interface core_pipe_exec_mdu_ctrl_if #(
  parameter int XLEN = 64
);
  logic            pipe_flush;
  logic            req_valid;
  logic            req_ready;
  logic            req_op_word;
  logic [7:0]      req_op;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rd;
  logic            mdu_valid;
  logic            mdu_op_word;
  logic [7:0]      mdu_op;
  logic [XLEN-1:0] mdu_rs1;
  logic [XLEN-1:0] mdu_rs2;
  logic            mdu_flush;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_rd;
  logic            busy;

  modport slave (
    input  pipe_flush, req_valid, req_op_word, req_op, req_rs1, req_rs2,
           rsp_ready, mdu_ready, mdu_rd,
    output req_ready, rsp_valid, rsp_rd, mdu_valid, mdu_op_word, mdu_op,
           mdu_rs1, mdu_rs2, mdu_flush, busy
  );

  modport master (
    output pipe_flush, req_valid, req_op_word, req_op, req_rs1, req_rs2,
           rsp_ready, mdu_ready, mdu_rd,
    input  req_ready, rsp_valid, rsp_rd, mdu_valid, mdu_op_word, mdu_op,
           mdu_rs1, mdu_rs2, mdu_flush, busy
  );
endinterface

// File: rtl/core_pipe_exec_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// core_pipe_exec_mdu_ctrl
//
// This block sequences operations between the execute stage and the
// multiply/divide unit. It accepts one request at a time and latches the
// operation and operands. It holds them steady at the MDU until the MDU
// reports ready, then buffers the result until the pipeline takes it. It
// pulses mdu_flush for one cycle so the MDU can re-arm.
//
// Division by zero and signed-division overflow never reach the MDU. Their
// architectural result is produced here, and the response is ready one
// cycle after accept.
//
// Ports:
//   g_clk     in   clock
//   g_resetn  in   asynchronous active-low reset
//   bus       slave view of core_pipe_exec_mdu_ctrl_if
//             (request, response, MDU and flush signals)
// ---------------------------------------------------------------------------
module core_pipe_exec_mdu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  core_pipe_exec_mdu_ctrl_if.slave   bus
);

  localparam int XL = XLEN - 1;

  // req_op / mdu_op bit positions
  localparam int OP_DIV  = 4;
  localparam int OP_DIVU = 5;
  localparam int OP_REM  = 6;
  localparam int OP_REMU = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CLR  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]  r_mdu_op;
  logic        r_mdu_op_word;
  logic [XL:0] r_mdu_rs1;
  logic [XL:0] r_mdu_rs2;
  logic [XL:0] r_rsp_rd;

  logic        w_req_ready;
  logic        w_accept;
  logic        w_rsp_valid;
  logic        w_mdu_valid;
  logic        w_mdu_flush;
  logic        w_mdu_done;

  logic        w_is_div;
  logic        w_is_sdiv;
  logic        w_is_rem;
  logic        w_rs2_zero;
  logic        w_rs1_min;
  logic        w_rs2_ones;
  logic        w_ovf;
  logic        w_fast;
  logic [XL:0] w_rs1_ext;
  logic [XL:0] w_fast_rd;

  // Sign-extend the low word of a value to the full datapath width.
  function automatic logic [XL:0] f_sext32(input logic [XL:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // ---------------------------------------------------------------------
  // Accept and fast-path decode (from the live request)
  // ---------------------------------------------------------------------
  assign w_req_ready = (r_state == S_IDLE) && !bus.pipe_flush;
  assign w_accept    = bus.req_valid && w_req_ready;

  assign w_is_div  = bus.req_op[OP_DIV] | bus.req_op[OP_DIVU] |
                     bus.req_op[OP_REM] | bus.req_op[OP_REMU];
  assign w_is_sdiv = bus.req_op[OP_DIV] | bus.req_op[OP_REM];
  assign w_is_rem  = bus.req_op[OP_REM] | bus.req_op[OP_REMU];

  // Word operations only examine the low 32 bits of the operands.
  assign w_rs2_zero = bus.req_op_word ? (bus.req_rs2[31:0] == 32'h0)
                                      : (bus.req_rs2 == '0);
  assign w_rs1_min  = bus.req_op_word ? (bus.req_rs1[31:0] == 32'h8000_0000)
                                      : (bus.req_rs1 == {1'b1, {XL{1'b0}}});
  assign w_rs2_ones = bus.req_op_word ? (&bus.req_rs2[31:0])
                                      : (&bus.req_rs2);

  assign w_ovf  = w_is_sdiv && w_rs1_min && w_rs2_ones;
  assign w_fast = w_is_div && (w_rs2_zero || w_ovf);

  assign w_rs1_ext = bus.req_op_word ? f_sext32(bus.req_rs1) : bus.req_rs1;

  // A zero divisor and an overflow cannot hold together, because overflow
  // needs rs2 all ones. So the zero check can safely take precedence.
  always_comb begin
    w_fast_rd = '0;
    if (w_rs2_zero) begin
      w_fast_rd = w_is_rem ? w_rs1_ext : '1;
    end else begin
      w_fast_rd = w_is_rem ? '0 : w_rs1_ext;
    end
  end

  // The MDU result is only taken while the sequencer is still waiting for it.
  assign w_mdu_done = (r_state == S_RUN) && bus.mdu_ready && !bus.pipe_flush;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_rsp_valid = 1'b0;
    w_mdu_valid = 1'b0;
    w_mdu_flush = bus.pipe_flush;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_fast ? S_RESP : S_RUN;
        end
      end
      S_RUN: begin
        w_mdu_valid = !bus.pipe_flush;
        if (bus.mdu_ready) begin
          w_state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        // The MDU is flushed here whether or not the pipeline takes the
        // result, so the flush pulse is always exactly one cycle.
        w_mdu_flush = 1'b1;
        w_rsp_valid = !bus.pipe_flush;
        w_state_nxt = bus.rsp_ready ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = !bus.pipe_flush;
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A pipeline flush overrides every other transition.
    if (bus.pipe_flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // Operation/operand latch and result buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_mdu_op      <= '0;
      r_mdu_op_word <= 1'b0;
      r_mdu_rs1     <= '0;
      r_mdu_rs2     <= '0;
      r_rsp_rd      <= '0;
    end else begin
      if (w_accept) begin
        r_mdu_op      <= bus.req_op;
        r_mdu_op_word <= bus.req_op_word;
        r_mdu_rs1     <= bus.req_rs1;
        r_mdu_rs2     <= bus.req_rs2;
      end
      if (w_accept && w_fast) begin
        r_rsp_rd <= w_fast_rd;
      end else if (w_mdu_done) begin
        r_rsp_rd <= bus.mdu_rd;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------
  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_rd      = r_rsp_rd;
  assign bus.mdu_valid   = w_mdu_valid;
  assign bus.mdu_op_word = r_mdu_op_word;
  assign bus.mdu_op      = r_mdu_op;
  assign bus.mdu_rs1     = r_mdu_rs1;
  assign bus.mdu_rs2     = r_mdu_rs2;
  assign bus.mdu_flush   = w_mdu_flush;
  assign bus.busy        = (r_state != S_IDLE);

  // A request must carry exactly one operation.
  a_req_op_onehot: assert property (
    @(posedge g_clk) disable iff (!g_resetn)
    w_accept |-> $onehot(bus.req_op)
  );

endmodule

// File: tb/tb_core_pipe_exec_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_pipe_exec_mdu_ctrl
//
// This bench drives the MDU sequencer through directed scenarios and then
// through randomized back-to-back operations. A behavioural MDU responds
// after a programmable latency. Expected results come from a plain
// arithmetic model of the RISC-V M-extension semantics.
// ---------------------------------------------------------------------------
module tb_core_pipe_exec_mdu_ctrl;
  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  core_pipe_exec_mdu_ctrl_if #(.XLEN(XLEN)) bus ();

  core_pipe_exec_mdu_ctrl #(.XLEN(XLEN)) dut (
    .g_clk    (clk),
    .g_resetn (rst_n),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural MDU state
  bit m_busy = 1'b0;
  int m_cnt  = 0;
  int m_lat  = 0;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M-extension result; k = 0..7 mul,mulh,mulhu,mulhsu,div,divu,rem,remu
  function automatic logic [63:0] ref_res(input int k, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb, sq;
    logic signed [31:0] wa, wb, wq;
    logic [31:0]        ua, ub;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (k)
      0: begin
        p = {64'b0, a} * {64'b0, b};
        return w ? sx32(p[31:0]) : p[63:0];
      end
      1: begin
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return p[127:64];
      end
      2: begin
        p = {64'b0, a} * {64'b0, b};
        return p[127:64];
      end
      3: begin
        p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});
        return p[127:64];
      end
      4: begin
        if (w) begin
          if (ub == 32'h0) return ONES;
          if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(ua);
          wq = wa / wb;
          return sx32(wq);
        end
        if (b == 64'h0) return ONES;
        if (a == MINV && b == ONES) return a;
        sq = sa / sb;
        return sq;
      end
      5: begin
        if (w) return (ub == 32'h0) ? ONES : sx32(ua / ub);
        return (b == 64'h0) ? ONES : a / b;
      end
      6: begin
        if (w) begin
          if (ub == 32'h0) return sx32(ua);
          if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'h0;
          wq = wa % wb;
          return sx32(wq);
        end
        if (b == 64'h0) return a;
        if (a == MINV && b == ONES) return 64'h0;
        sq = sa % sb;
        return sq;
      end
      7: begin
        if (w) return (ub == 32'h0) ? sx32(ua) : sx32(ua % ub);
        return (b == 64'h0) ? a : a % b;
      end
      default: return 64'h0;
    endcase
  endfunction

  // Whether the operation is answered locally (zero divisor or signed overflow).
  function automatic bit expect_fast(input int k, input bit w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb;
    ea = w ? sx32(a[31:0]) : a;
    eb = w ? sx32(b[31:0]) : b;
    if (k < 4) return 1'b0;
    if (eb == 64'h0) return 1'b1;
    if ((k == 4 || k == 6) && eb == ONES && ea == (w ? sx32(32'h8000_0000) : MINV))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic int op_idx(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      0: return 64'h0;
      1: return ONES;
      2: return MINV;
      3: return {$urandom, 32'h8000_0000};
      4: return {$urandom, 32'hFFFF_FFFF};
      5: return {$urandom, 32'h0};
      6: return 64'($urandom_range(0, 1000));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Behavioural MDU, advanced once per cycle just after the active edge.
  task automatic mdu_update();
    if (bus.mdu_ready) begin
      bus.mdu_ready = 1'b0;
      m_busy = 1'b0;
    end else if (bus.mdu_flush) begin
      m_busy = 1'b0;
    end else if (bus.mdu_valid) begin
      if (!m_busy) begin
        m_busy = 1'b1;
        m_cnt  = m_lat;
      end
      if (m_cnt == 0) begin
        bus.mdu_ready = 1'b1;
        bus.mdu_rd = ref_res(op_idx(bus.mdu_op), bus.mdu_op_word, bus.mdu_rs1, bus.mdu_rs2);
      end else begin
        m_cnt--;
      end
    end
    if (!bus.mdu_ready) bus.mdu_rd = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mdu_update();
  endtask

  // One complete request/response transaction starting in IDLE.
  task automatic do_op(input int k, input bit w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input int bp);
    bit         fast;
    int         waited;
    logic [7:0] oh;
    fast  = expect_fast(k, w, a, b);
    oh    = 8'b1 << k;
    m_lat = lat;
    chk1("idle_req_ready", bus.req_ready, 1'b1);
    bus.req_valid   = 1'b1;
    bus.req_op      = oh;
    bus.req_op_word = w;
    bus.req_rs1     = a;
    bus.req_rs2     = b;
    bus.rsp_ready   = (bp == 0);
    tick();
    bus.req_valid   = 1'b0;
    bus.req_op      = 8'b1 << $urandom_range(0, 7);
    bus.req_op_word = 1'($urandom);
    bus.req_rs1     = {$urandom, $urandom};
    bus.req_rs2     = {$urandom, $urandom};
    if (fast) begin
      chk1("fast_mdu_valid", bus.mdu_valid, 1'b0);
    end else begin
      waited = 0;
      while (!bus.rsp_valid && waited < 200) begin
        chk1("run_mdu_valid", bus.mdu_valid, 1'b1);
        chk1("run_mdu_flush", bus.mdu_flush, 1'b0);
        chk1("run_req_ready", bus.req_ready, 1'b0);
        chk64("run_rs1", bus.mdu_rs1, a);
        chk64("run_rs2", bus.mdu_rs2, b);
        chk64("run_op", {55'b0, bus.mdu_op_word, bus.mdu_op}, {55'b0, w, oh});
        tick();
        waited++;
      end
    end
    chk1("rsp_valid", bus.rsp_valid, 1'b1);
    chk64("rsp_rd", bus.rsp_rd, exp);
    chk1("rsp_mdu_flush", bus.mdu_flush, !fast);
    chk1("rsp_mdu_valid", bus.mdu_valid, 1'b0);
    chk1("rsp_busy", bus.busy, 1'b1);
    for (int i = 1; i < bp; i++) begin
      tick();
      chk1("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk64("bp_rsp_rd", bus.rsp_rd, exp);
      chk1("bp_req_ready", bus.req_ready, 1'b0);
      chk1("bp_mdu_flush", bus.mdu_flush, 1'b0);
      chk1("bp_mdu_valid", bus.mdu_valid, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("done_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("done_busy", bus.busy, 1'b0);
    chk1("done_req_ready", bus.req_ready, 1'b1);
    chk1("done_mdu_flush", bus.mdu_flush, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk64({tag, "_rsp_rd"}, bus.rsp_rd, 64'h0);
    chk1({tag, "_mdu_valid"}, bus.mdu_valid, 1'b0);
    chk64({tag, "_mdu_op"}, {56'b0, bus.mdu_op}, 64'h0);
    chk1({tag, "_mdu_op_word"}, bus.mdu_op_word, 1'b0);
    chk64({tag, "_mdu_rs1"}, bus.mdu_rs1, 64'h0);
    chk64({tag, "_mdu_rs2"}, bus.mdu_rs2, 64'h0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_mdu_flush"}, bus.mdu_flush, 1'b0);
    chk1({tag, "_req_ready"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    int          k;
    bit          w;
    logic [63:0] a, b;

    bus.pipe_flush  = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_op_word = 1'b0;
    bus.req_op      = 8'h01;
    bus.req_rs1     = '0;
    bus.req_rs2     = '0;
    bus.rsp_ready   = 1'b0;
    bus.mdu_ready   = 1'b0;
    bus.mdu_rd      = '0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("por");
    bus.pipe_flush = 1'b1;
    #1;
    chk1("por_flush_mdu_flush", bus.mdu_flush, 1'b1);
    chk1("por_flush_req_ready", bus.req_ready, 1'b0);
    bus.pipe_flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // mul 7*6 with a 3-cycle MDU
    do_op(0, 1'b0, 64'd7, 64'd6, 64'd42, 3, 0);

    // Divide by zero
    do_op(5, 1'b0, 64'd100, 64'd0, ONES, 0, 0);
    do_op(6, 1'b1, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 0, 0);

    // Signed overflow
    do_op(4, 1'b0, MINV, ONES, MINV, 0, 0);
    do_op(6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 0, 0);

    // divw -20/3 under backpressure
    do_op(4, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 4, 5);

    // Flush in the middle of a long mulh
    m_lat = 100;
    bus.req_valid = 1'b1;
    bus.req_op    = 8'h02;
    bus.req_op_word = 1'b0;
    bus.req_rs1   = {$urandom, $urandom};
    bus.req_rs2   = {$urandom, $urandom};
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("fl_run_mdu_valid", bus.mdu_valid, 1'b1);
      tick();
    end
    bus.pipe_flush = 1'b1;
    #1;
    chk1("fl_mdu_flush", bus.mdu_flush, 1'b1);
    chk1("fl_mdu_valid", bus.mdu_valid, 1'b0);
    chk1("fl_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("fl_req_ready", bus.req_ready, 1'b0);
    tick();
    bus.pipe_flush = 1'b0;
    #1;
    chk1("fl_idle_busy", bus.busy, 1'b0);
    chk1("fl_idle_req_ready", bus.req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("fl_no_rsp", bus.rsp_valid, 1'b0);
    end
    bus.rsp_ready = 1'b0;
    do_op(2, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);

    // Flush while a fast result waits; a request held during flush is ignored
    bus.req_valid = 1'b1;
    bus.req_op    = 8'h20;
    bus.req_op_word = 1'b0;
    bus.req_rs1   = 64'd5;
    bus.req_rs2   = 64'd0;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk1("flr_rsp_valid", bus.rsp_valid, 1'b1);
    bus.pipe_flush = 1'b1;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    #1;
    chk1("flr_rsp_valid_flushed", bus.rsp_valid, 1'b0);
    chk1("flr_req_ready", bus.req_ready, 1'b0);
    chk1("flr_mdu_flush", bus.mdu_flush, 1'b1);
    tick();
    chk1("flr_no_accept", bus.busy, 1'b0);
    bus.pipe_flush = 1'b0;
    bus.req_valid  = 1'b0;
    bus.rsp_ready  = 1'b0;
    #1;
    chk1("flr_req_ready_after", bus.req_ready, 1'b1);
    chk1("flr_rsp_valid_after", bus.rsp_valid, 1'b0);

    // Asynchronous reset while the MDU is running
    m_lat = 50;
    bus.req_valid = 1'b1;
    bus.req_op    = 8'h10;
    bus.req_rs1   = 64'd1000;
    bus.req_rs2   = 64'd7;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("ar_run_mdu_valid", bus.mdu_valid, 1'b1);
      tick();
    end
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 1'b0;
    bus.mdu_ready = 1'b0;
    tick();
    chk1("ar_after_busy", bus.busy, 1'b0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      w = (k == 0 || k >= 4) ? 1'($urandom) : 1'b0;
      a = pick($urandom_range(0, 9));
      b = pick($urandom_range(0, 9));
      do_op(k, w, a, b, ref_res(k, w, a, b), $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
